// File: rtl/mem_pkg.sv
// Shared definitions for the data RAM controller: access-size encodings,
// sequencer states and the byte-lane helpers used by the store and load paths.
package mem_pkg;

  localparam logic [1:0] MODE_WORD = 2'b00;
  localparam logic [1:0] MODE_HALF = 2'b01;
  localparam logic [1:0] MODE_BYTE = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Little-endian lane enables; the reserved encoding acts as a full word.
  function automatic logic [3:0] lane_mask(input logic [1:0] mode, input logic [1:0] offset);
    logic [3:0] mask;
    case (mode)
      MODE_HALF: mask = offset[1] ? 4'b1100 : 4'b0011;
      MODE_BYTE: mask = 4'b0001 << offset;
      default:   mask = 4'b1111;
    endcase
    return mask;
  endfunction

  function automatic logic is_aligned(input logic [1:0] mode, input logic [1:0] offset);
    logic ok;
    case (mode)
      MODE_HALF: ok = (offset[0] == 1'b0);
      MODE_BYTE: ok = 1'b1;
      default:   ok = (offset == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ram_lane_extend.sv
// Picks the byte/halfword/word addressed by offset out of a 32-bit word and
// sign- or zero-extends it to 32 bits. Purely combinational.
module ram_lane_extend
  import mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_mode,
  input  logic [1:0]  i_offset,
  input  logic        i_sign_ext,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[8*i_offset +: 8];
    w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
    case (i_mode)
      MODE_HALF: o_data = {{16{i_sign_ext & w_half[15]}}, w_half};
      MODE_BYTE: o_data = {{24{i_sign_ext & w_byte[7]}}, w_byte};
      default:   o_data = i_word;
    endcase
  end

endmodule

// File: rtl/data_ram_ctrl.sv
// Byte-addressable data memory with sized loads/stores, misalignment pulses,
// a 1-cycle registered read and a counter-driven clear sequencer.
module data_ram_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS    = 1024,
  parameter int ADDR_WIDTH     = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  store,
  input  logic                  load,
  input  logic [1:0]            mode,
  input  logic                  sign_ext,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           data,
  output logic [31:0]           result,
  output logic                  result_valid,
  output logic                  misaligned,
  output logic                  busy
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0]      r_mem [DEPTH_WORDS];
  logic [31:0]      r_rd_word;
  state_t           r_state, w_state_next;
  logic [IDX_W-1:0] r_cnt, w_cnt_next;

  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_off;
  logic             w_aligned;
  logic             w_we;
  logic [3:0]       w_we_mask;
  logic [IDX_W-1:0] w_wr_idx;
  logic [31:0]      w_wr_data;
  logic             w_rd_en;
  logic             w_mis;
  logic [31:0]      w_ext;
  logic             w_addr_unused;

  logic [1:0] r_ld_mode;
  logic [1:0] r_ld_off;
  logic       r_ld_sext;
  logic       r_have_data;
  logic       r_valid;
  logic       r_mis;

  // Upper address bits are intentionally dropped so accesses wrap.
  assign w_addr_unused = ^address;
  assign w_idx         = address[IDX_W+1:2];
  assign w_off         = address[1:0];
  assign w_aligned     = is_aligned(mode, w_off);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_we         = 1'b0;
    w_we_mask    = 4'b0000;
    w_wr_idx     = w_idx;
    w_wr_data    = data;
    w_rd_en      = 1'b0;
    w_mis        = 1'b0;
    case (r_state)
      IDLE: begin
        if (clear) begin
          w_state_next = CLEAR;
          w_cnt_next   = '0;
        end else if ((store || load) && !w_aligned) begin
          w_mis = 1'b1;
        end else begin
          if (store) begin
            w_we      = 1'b1;
            w_we_mask = lane_mask(mode, w_off);
            case (mode)
              MODE_HALF: w_wr_data = {2{data[15:0]}};
              MODE_BYTE: w_wr_data = {4{data[7:0]}};
              default:   w_wr_data = data;
            endcase
          end
          w_rd_en = load;
        end
      end
      CLEAR: begin
        w_we      = 1'b1;
        w_we_mask = 4'b1111;
        w_wr_idx  = r_cnt;
        w_wr_data = '0;
        if (clear) begin
          w_cnt_next = '0;
        end else if (r_cnt == IDX_W'(DEPTH_WORDS - 1)) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Nonblocking read and write of the same word give read-before-write.
  always_ff @(posedge clock) begin
    if (w_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_we_mask[i]) r_mem[w_wr_idx][8*i +: 8] <= w_wr_data[8*i +: 8];
      end
    end
    if (w_rd_en) r_rd_word <= r_mem[w_idx];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ld_mode   <= MODE_WORD;
      r_ld_off    <= 2'b00;
      r_ld_sext   <= 1'b0;
      r_have_data <= 1'b0;
      r_valid     <= 1'b0;
      r_mis       <= 1'b0;
    end else begin
      r_valid <= w_rd_en;
      r_mis   <= w_mis;
      if (w_rd_en) begin
        r_ld_mode   <= mode;
        r_ld_off    <= w_off;
        r_ld_sext   <= sign_ext;
        r_have_data <= 1'b1;
      end
    end
  end

  ram_lane_extend u_extend (
    .i_word     (r_rd_word),
    .i_mode     (r_ld_mode),
    .i_offset   (r_ld_off),
    .i_sign_ext (r_ld_sext),
    .o_data     (w_ext)
  );

  assign result       = r_have_data ? w_ext : 32'h0;
  assign result_valid = r_valid;
  assign misaligned   = r_mis;
  assign busy         = (r_state == CLEAR);

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Directed bench for data_ram_ctrl (16 words, clear on reset): vector table
// for loads/stores plus hand sequences for reset and mid-run clear.
module tb_data_ram_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        store = 1'b0;
  logic        load = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        sign_ext = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] data = '0;
  logic [31:0] result;
  logic        result_valid;
  logic        misaligned;
  logic        busy;

  int tests = 0;
  int fails = 0;

  data_ram_ctrl #(
    .DEPTH_WORDS    (16),
    .ADDR_WIDTH     (32),
    .CLEAR_ON_RESET (1)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .clear        (clear),
    .store        (store),
    .load         (load),
    .mode         (mode),
    .sign_ext     (sign_ext),
    .address      (address),
    .data         (data),
    .result       (result),
    .result_valid (result_valid),
    .misaligned   (misaligned),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        st;
    logic        ld;
    logic [1:0]  md;
    logic        sx;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        ev;
    logic        em;
    logic [31:0] er;
  } vec_t;

  vec_t vecs[24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: 0x%08h", name, act);
    end
  endtask

  initial begin
    int n;
    vecs[0]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h04, 32'h0,        1'b1, 1'b0, 32'h00000000};
    vecs[1]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h04, 32'd100,      1'b0, 1'b0, 32'h00000000};
    vecs[2]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h08, 32'd200,      1'b0, 1'b0, 32'h00000000};
    vecs[3]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h04, 32'h0,        1'b1, 1'b0, 32'd100};
    vecs[4]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h08, 32'h0,        1'b1, 1'b0, 32'd200};
    vecs[5]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h11223344, 1'b0, 1'b0, 32'd200};
    vecs[6]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h12, 32'h000000AA, 1'b0, 1'b0, 32'd200};
    vecs[7]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'h0,        1'b1, 1'b0, 32'h11AA3344};
    vecs[8]  = '{1'b0, 1'b1, 2'b10, 1'b1, 32'h12, 32'h0,        1'b1, 1'b0, 32'hFFFFFFAA};
    vecs[9]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h12, 32'h0,        1'b1, 1'b0, 32'h000000AA};
    vecs[10] = '{1'b0, 1'b1, 2'b01, 1'b1, 32'h12, 32'h0,        1'b1, 1'b0, 32'h000011AA};
    vecs[11] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h06, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h000011AA};
    vecs[12] = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h04, 32'h0,        1'b1, 1'b0, 32'd100};
    vecs[13] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h05, 32'h0,        1'b0, 1'b1, 32'd100};
    vecs[14] = '{1'b1, 1'b1, 2'b00, 1'b0, 32'h20, 32'hDEADBEEF, 1'b1, 1'b0, 32'h00000000};
    vecs[15] = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h20, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF};
    vecs[16] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h44, 32'h55667788, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[17] = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h04, 32'h0,        1'b1, 1'b0, 32'h55667788};
    vecs[18] = '{1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 32'h0,        1'b1, 1'b0, 32'h11AA3344};
    vecs[19] = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h22, 32'h00001234, 1'b0, 1'b0, 32'h11AA3344};
    vecs[20] = '{1'b0, 1'b1, 2'b01, 1'b1, 32'h20, 32'h0,        1'b1, 1'b0, 32'hFFFFBEEF};
    vecs[21] = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h20, 32'h0,        1'b1, 1'b0, 32'h1234BEEF};
    vecs[22] = '{1'b1, 1'b1, 2'b00, 1'b0, 32'h21, 32'h0BADF00D, 1'b0, 1'b1, 32'h1234BEEF};
    vecs[23] = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h23, 32'h0,        1'b1, 1'b0, 32'h00000012};

    // Reset state and the post-reset clear length.
    repeat (3) @(negedge clock);
    chk("reset result", result, 32'h0);
    chk("reset result_valid", {31'b0, result_valid}, 32'd0);
    chk("reset misaligned", {31'b0, misaligned}, 32'd0);
    chk("reset busy", {31'b0, busy}, 32'd1);
    reset = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clock);
    end
    chk("reset clear busy cycles", n, 32'd16);

    for (int i = 0; i < 24; i++) begin
      store    = vecs[i].st;
      load     = vecs[i].ld;
      mode     = vecs[i].md;
      sign_ext = vecs[i].sx;
      address  = vecs[i].addr;
      data     = vecs[i].wd;
      @(negedge clock);
      chk($sformatf("vec%0d result_valid", i), {31'b0, result_valid}, {31'b0, vecs[i].ev});
      chk($sformatf("vec%0d misaligned", i), {31'b0, misaligned}, {31'b0, vecs[i].em});
      chk($sformatf("vec%0d result", i), result, vecs[i].er);
    end
    store = 1'b0;
    load  = 1'b0;
    @(negedge clock);
    chk("misaligned single pulse", {31'b0, misaligned}, 32'd0);

    // Clear, then restart it after five busy cycles.
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    n = 0;
    while (busy && n < 5) begin
      n++;
      @(negedge clock);
    end
    chk("clear entered busy", n, 32'd5);
    clear = 1'b1;
    @(negedge clock);
    clear   = 1'b0;
    store   = 1'b1;
    load    = 1'b1;
    mode    = 2'b00;
    address = 32'h0;
    data    = 32'hCAFEF00D;
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (n > 1) chk($sformatf("busy cyc%0d no result_valid", n), {31'b0, result_valid}, 32'd0);
      @(negedge clock);
    end
    store = 1'b0;
    load  = 1'b0;
    chk("restarted clear busy cycles", n, 32'd16);
    chk("after clear no result_valid", {31'b0, result_valid}, 32'd0);

    address = 32'h0;
    load    = 1'b1;
    @(negedge clock);
    chk("busy store dropped valid", {31'b0, result_valid}, 32'd1);
    chk("busy store dropped data", result, 32'h0);
    address = 32'h10;
    @(negedge clock);
    load = 1'b0;
    chk("cleared word4 valid", {31'b0, result_valid}, 32'd1);
    chk("cleared word4 data", result, 32'h0);
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_ram_ctrl.md
Name: data_ram_ctrl

Overview:
- Parametrised data memory for the single-cycle/pipelined CPU datapath; successor to the flat 32-bit word RAM.
- Adds byte/halfword/word access with sign or zero extension, misalignment detection, a registered 1-cycle read and a counter-driven clear sequencer.
- The sequencer replaces the one-cycle "zero everything" reset, so deep memories map to block RAM.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, at least 2.
- ADDR_WIDTH, 32, byte-address width presented by the CPU.
- CLEAR_ON_RESET, 1, when 1 the memory is zeroed after reset deasserts; when 0 the contents are left as-is.
- IDX_W (localparam), $clog2(DEPTH_WORDS), word-index width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- clear  in  1  synchronous request to zero the whole memory.
- store  in  1  write enable for this cycle.
- load  in  1  read request for this cycle.
- mode  in  2  access size: 00 word, 01 halfword, 10 byte, 11 reserved (treated as word).
- sign_ext  in  1  loads only: 1 sign-extends, 0 zero-extends.
- address  in  ADDR_WIDTH  byte address.
- data  in  32  store data; the sub-word operand sits in the low bits.
- result  out  32  load data, registered.
- result_valid  out  1  one-cycle pulse, one cycle after an accepted load.
- misaligned  out  1  one-cycle pulse, one cycle after a rejected misaligned access.
- busy  out  1  high while the clear sequence runs.

Behaviour:
- Reset values: result=0, result_valid=0, misaligned=0. busy=CLEAR_ON_RESET. Clear counter=0. FSM=CLEAR if CLEAR_ON_RESET, else IDLE.
- Memory contents are not reset asynchronously.
- FSM state IDLE:
  - clear=1 moves to CLEAR with counter=0; busy rises the next cycle.
  - Otherwise store and load are serviced.
- FSM state CLEAR:
  - Each cycle writes 0 to word[counter], then increments the counter.
  - After writing word DEPTH_WORDS-1, go to IDLE. The sequence takes exactly DEPTH_WORDS cycles with busy high.
  - store and load are ignored: no write, no result_valid, no misaligned pulse.
  - clear=1 during CLEAR restarts the counter at 0.
  - Reset during CLEAR restarts per the reset rules.
- Address decode:
  - word index = address[IDX_W+1:2]; byte offset = address[1:0].
  - Bits above IDX_W+1 are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
- Alignment:
  - Word requires offset=0.
  - Halfword requires offset[0]=0.
  - Byte is always aligned.
- Store (IDLE, aligned), written at the clock edge with per-byte lanes:
  - Word: writes data[31:0].
  - Halfword: writes data[15:0] into lanes {offset+1, offset}.
  - Byte: writes data[7:0] into lane offset.
  - All other lanes are unchanged. Little-endian: lane 0 = bits 7:0.
- Load (IDLE, aligned):
  - The word is read at the edge; the selected lanes are extended per sign_ext.
  - result is updated and result_valid=1 in the following cycle. Latency is 1.
  - result holds its value until the next accepted load.
- Misaligned store or load (IDLE):
  - No memory write; result is unchanged and result_valid stays 0.
  - misaligned=1 for one cycle. If both store and load are misaligned, one pulse only.
- store and load in the same cycle at the same word: read-before-write. The load returns the old contents; the new data is visible to the next load.
- clear and store/load in the same IDLE cycle: clear wins and the access is dropped.
- Reserved mode 11 behaves exactly as word.

Decomposition:
- Shared package `mem_pkg`:
  - Mode encodings MODE_WORD/MODE_HALF/MODE_BYTE.
  - FSM state enum {IDLE, CLEAR}.
  - Byte-lane mask function from (mode, offset).
- One sub-module, `ram_lane_extend`: combinational extract plus sign/zero extension from (word, mode, offset, sign_ext) to 32 bits, reusable by the load/store unit.
- Storage is an inferred array with byte-enable write.

Test Plan:
- Reset pulse with DEPTH_WORDS=16, CLEAR_ON_RESET=1: busy high for exactly 16 cycles after reset falls. A load at 0x4 after that gives result=0 and result_valid=1 one cycle later.
- Word store 100 at 0x4, word store 200 at 0x8. Load 0x4 gives 100, load 0x8 gives 200, each valid one cycle after the request.
- Word store 0x11223344 at 0x10. Then:
  - Byte store 0xAA at 0x12.
  - Word load gives 0x11AA3344.
  - Byte load at 0x12 with sign_ext=1 gives 0xFFFFFFAA; with sign_ext=0 gives 0x000000AA.
  - Half load at 0x12 with sign_ext=1 gives 0x000011AA.
- Misaligned accesses:
  - Word store at 0x6 gives a misaligned pulse and memory is unchanged.
  - Half load at 0x5 gives a misaligned pulse, no result_valid, and result keeps its previous value.
- Store 0xDEADBEEF and load at 0x20 in the same cycle: the load returns the old value 0. The next load returns 0xDEADBEEF.
- Address wrap: with DEPTH_WORDS=16, a store at 0x44 is readable at 0x04.
- clear mid-run, with DEPTH_WORDS=16:
  - clear asserted at cycle 5 of the sequence restarts it, so 16 more busy cycles follow.
  - Stores issued while busy are not written; loads issued while busy give no result_valid.
